// File: rtl/xbar_mcast_scheduler_if.sv
// Handshake bundle between the input FIFO heads, the scheduler and the output muxes.
// grant[j*NUM_PORTS+i] = output j takes input i; req_target[i*NUM_PORTS +: NUM_PORTS] = mask of input i.
interface xbar_mcast_scheduler_if #(
   parameter int NUM_PORTS = 4
);
   logic [NUM_PORTS-1:0]           req_valid;
   logic [NUM_PORTS*NUM_PORTS-1:0] req_target;
   logic [NUM_PORTS-1:0]           out_ready;
   logic [NUM_PORTS*NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0]           deq;
   logic [NUM_PORTS-1:0]           busy;
   logic                           err;

   modport master (
      output req_valid, req_target, out_ready,
      input  grant, deq, busy, err
   );

   modport slave (
      input  req_valid, req_target, out_ready,
      output grant, deq, busy, err
   );
endinterface

// File: rtl/xbar_mcast_scheduler.sv
// Multicast crossbar scheduler: per-output round-robin, heads popped once fully delivered.
// Optional age-based urgency priority is enabled by defining XBAR_AGE_PRIO_EN.
module xbar_mcast_scheduler #(
   parameter int NUM_PORTS = 4,
   parameter int AGE_W     = 4,
   parameter int AGE_LIMIT = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   xbar_mcast_scheduler_if.slave bus
);
   localparam int N  = NUM_PORTS;
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      ACTIVE
   } st_e;

   st_e                  state_q [N];
   st_e                  state_d [N];
   logic [N-1:0]         rem_q   [N];
   logic [N-1:0]         rem_d   [N];
   logic [N-1:0][PW-1:0] ptr_q;
   logic [N-1:0][PW-1:0] ptr_d;
   logic                 err_q;
   logic                 err_d;

   logic [N-1:0]         eff     [N];
   logic [N-1:0]         srv     [N];
   logic [N-1:0][N-1:0]  r;
   logic [N-1:0][N-1:0]  gnt;
   logic [N-1:0]         deq_c;
   logic [N-1:0]         busy_c;
   logic [N-1:0]         urg;

   // Saturating counter must be able to reach the urgency threshold.
   if (AGE_W < 1 || AGE_LIMIT < 1 || AGE_LIMIT >= (1 << AGE_W)) begin : g_cfg_chk
      $error("xbar_mcast_scheduler: AGE_LIMIT not reachable with AGE_W bits");
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         eff[i] = (state_q[i] == ACTIVE) ? rem_q[i]
                                         : bus.req_target[i*N +: N];
      end
   end

   always_comb begin
      r = '0;
      for (int j = 0; j < N; j++) begin
         for (int i = 0; i < N; i++) begin
            r[j][i] = bus.req_valid[i] & eff[i][j]
                    & bus.out_ready[j] & ~rst;
         end
      end
   end

`ifdef XBAR_AGE_PRIO_EN
   logic [AGE_W-1:0] age_q [N];
   logic [AGE_W-1:0] age_d [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         urg[i]   = (age_q[i] >= AGE_W'(AGE_LIMIT));
         age_d[i] = age_q[i];
         if (srv[i] != '0) begin
            age_d[i] = '0;
         end else if (bus.req_valid[i] && (age_q[i] != '1)) begin
            age_d[i] = age_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            age_q[i] <= '0;
         end else begin
            age_q[i] <= age_d[i];
         end
      end
   end
`else
   assign urg = '0;
`endif

   // Each output searches cyclically from its pointer; urgent inputs first.
   always_comb begin
      logic          found;
      logic [PW-1:0] idx;
      logic [PW-1:0] cand;
      gnt   = '0;
      ptr_d = ptr_q;
      for (int j = 0; j < N; j++) begin
         found = 1'b0;
         idx   = '0;
         cand  = '0;
         for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr_q[j]) + k) % N);
            if (!found && r[j][cand] && urg[cand]) begin
               found = 1'b1;
               idx   = cand;
            end
         end
         for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr_q[j]) + k) % N);
            if (!found && r[j][cand]) begin
               found = 1'b1;
               idx   = cand;
            end
         end
         if (found) begin
            gnt[j][idx] = 1'b1;
            ptr_d[j]    = PW'((int'(idx) + 1) % N);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         srv[i] = '0;
         for (int j = 0; j < N; j++) begin
            srv[i][j] = gnt[j][i];
         end
      end
   end

   always_comb begin
      logic [N-1:0] nrem;
      nrem  = '0;
      deq_c = '0;
      err_d = err_q;
      for (int i = 0; i < N; i++) begin
         nrem       = eff[i] & ~srv[i];
         state_d[i] = state_q[i];
         rem_d[i]   = rem_q[i];
         if (bus.req_valid[i] && (srv[i] != '0) && (nrem == '0)) begin
            deq_c[i]   = 1'b1;
            state_d[i] = IDLE;
            rem_d[i]   = '0;
         end else if (srv[i] != '0) begin
            state_d[i] = ACTIVE;
            rem_d[i]   = nrem;
         end else if (bus.req_valid[i] && !rst
                      && (state_q[i] == IDLE) && (eff[i] == '0)) begin
            deq_c[i] = 1'b1;
         end
         if ((state_q[i] == ACTIVE) && !bus.req_valid[i]) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= IDLE;
            rem_q[i]   <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         err_q <= err_d;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            rem_q[i]   <= rem_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         busy_c[i] = (state_q[i] == ACTIVE);
      end
   end

   assign bus.grant = gnt;
   assign bus.deq   = deq_c;
   assign bus.busy  = busy_c;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_xbar_mcast_scheduler.sv
// Directed bench for xbar_mcast_scheduler: reset, round-robin, multicast,
// partial service, zero target, protocol violation and age priority.
module tb_xbar_mcast_scheduler;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   xbar_mcast_scheduler_if #(.NUM_PORTS(4)) bus ();

   xbar_mcast_scheduler #(
      .NUM_PORTS(4),
      .AGE_W    (4),
      .AGE_LIMIT(12)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst            = 1'b1;
      bus.req_valid  = 4'hF;
      bus.req_target = 16'hFFFF;
      bus.out_ready  = 4'hF;
      #1;

      // Reset holds grant/deq low
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_grant", 32'(bus.grant), 32'h0);
         chk("rst_deq", 32'(bus.deq), 32'h0);
         step();
      end
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);

      // Round-robin on output 0
      rst            = 1'b0;
      bus.req_target = 16'h1111;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rr_grant", 32'(bus.grant), 32'h1 << k);
         chk("rr_deq", 32'(bus.deq), 32'h1 << k);
         step();
      end

      // Multicast from input 2 to outputs 0,1,3
      bus.req_valid  = 4'b0100;
      bus.req_target = 16'h0B00;
      @(negedge clk);
      chk("mc_grant", 32'(bus.grant), 32'h4044);
      chk("mc_deq", 32'(bus.deq), 32'h4);
      step();
      chk("mc_busy", 32'(bus.busy), 32'h0);

      // Partial service of input 0
      bus.req_valid  = 4'b0001;
      bus.req_target = 16'h0006;
      bus.out_ready  = 4'b0010;
      @(negedge clk);
      chk("part_g0", 32'(bus.grant), 32'h0010);
      chk("part_d0", 32'(bus.deq), 32'h0);
      step();
      chk("part_busy0", 32'(bus.busy), 32'h1);
      @(negedge clk);
      chk("part_g1", 32'(bus.grant), 32'h0);
      chk("part_d1", 32'(bus.deq), 32'h0);
      step();
      chk("part_busy1", 32'(bus.busy), 32'h1);
      bus.out_ready = 4'hF;
      @(negedge clk);
      chk("part_g2", 32'(bus.grant), 32'h0100);
      chk("part_d2", 32'(bus.deq), 32'h1);
      step();
      chk("part_busy2", 32'(bus.busy), 32'h0);

      // Zero target discard
      bus.req_valid  = 4'b1000;
      bus.req_target = 16'h0000;
      @(negedge clk);
      chk("zero_grant", 32'(bus.grant), 32'h0);
      chk("zero_deq", 32'(bus.deq), 32'h8);
      step();
      chk("zero_err", 32'(bus.err), 32'h0);
      chk("zero_busy", 32'(bus.busy), 32'h0);

      // Protocol violation on input 1
      bus.req_valid  = 4'b0010;
      bus.req_target = 16'h0060;
      bus.out_ready  = 4'b0010;
      @(negedge clk);
      chk("viol_g0", 32'(bus.grant), 32'h0020);
      step();
      chk("viol_busy0", 32'(bus.busy), 32'h2);
      chk("viol_err0", 32'(bus.err), 32'h0);
      bus.req_valid = 4'b0000;
      bus.out_ready = 4'hF;
      @(negedge clk);
      chk("viol_g1", 32'(bus.grant), 32'h0);
      chk("viol_d1", 32'(bus.deq), 32'h0);
      step();
      chk("viol_err1", 32'(bus.err), 32'h1);
      chk("viol_busy1", 32'(bus.busy), 32'h2);
      bus.req_valid  = 4'b0010;
      bus.req_target = 16'h00F0;
      @(negedge clk);
      chk("viol_g2", 32'(bus.grant), 32'h0200);
      chk("viol_d2", 32'(bus.deq), 32'h2);
      step();
      chk("viol_err2", 32'(bus.err), 32'h1);
      chk("viol_busy2", 32'(bus.busy), 32'h0);

      // Reset clears sticky error
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_grant", 32'(bus.grant), 32'h0);
      chk("rst2_deq", 32'(bus.deq), 32'h0);
      step();
      chk("rst2_err", 32'(bus.err), 32'h0);

      // Aging: input 3 starved on output 0 for 12 cycles
      rst            = 1'b0;
      bus.req_valid  = 4'b1000;
      bus.req_target = 16'h1000;
      bus.out_ready  = 4'b0000;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("age_wait_grant", 32'(bus.grant), 32'h0);
         step();
      end
      bus.req_valid  = 4'hF;
      bus.req_target = 16'h1111;
      bus.out_ready  = 4'b0001;
      @(negedge clk);
`ifdef XBAR_AGE_PRIO_EN
      chk("age_grant", 32'(bus.grant), 32'h0008);
      chk("age_deq", 32'(bus.deq), 32'h8);
`else
      chk("age_grant", 32'(bus.grant), 32'h0001);
      chk("age_deq", 32'(bus.deq), 32'h1);
`endif
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
